uart_csr: RTL and testbench

UART_CSR -- requirements
Module: uart_csr

---
 rtl/uart_pkg.sv | 47 ++++
 rtl/uart_rx_timeout.sv | 34 +++
 rtl/uart_csr.sv | 183 ++++++++++++++++++
 tb/tb_uart_csr.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Register map, interrupt bit positions, line_ctrl layout and reset images for the UART CSR block.
// Shared by uart_csr and uart_rx_timeout.
package uart_pkg;

    localparam logic [31:0] ADDR_CTRL       = 32'd0;
    localparam logic [31:0] ADDR_STATUS     = 32'd1;
    localparam logic [31:0] ADDR_TX_DATA    = 32'd2;
    localparam logic [31:0] ADDR_RX_DATA    = 32'd3;
    localparam logic [31:0] ADDR_BAUD_DIV   = 32'd4;
    localparam logic [31:0] ADDR_INT_EN     = 32'd5;
    localparam logic [31:0] ADDR_INT_STAT   = 32'd6;
    localparam logic [31:0] ADDR_FIFO_CTRL  = 32'd7;
    localparam logic [31:0] ADDR_RX_TIMEOUT = 32'd8;

    localparam int INT_TX_WM   = 0;
    localparam int INT_RX_WM   = 1;
    localparam int INT_FRAME   = 2;
    localparam int INT_PARITY  = 3;
    localparam int INT_OVERRUN = 4;
    localparam int INT_RX_TMO  = 5;
    localparam int INT_W       = 6;

    // line_ctrl: [1:0] char bits minus 5, [3:2] parity (0 none, 1 even, 2 odd), [4] two stop bits
    localparam int LC_W        = 5;
    localparam int LC_BITS_LSB = 0;
    localparam int LC_PAR_LSB  = 2;
    localparam int LC_STOP_BIT = 4;
    localparam int CTRL_LC_LSB = 4;

    localparam logic [LC_W-1:0] LC_RST   = 5'b00011;
    localparam logic [15:0]     BAUD_RST = 16'd4;
    localparam logic [31:0]     CTRL_RST = 32'(LC_RST) << CTRL_LC_LSB;

    // Writable bits of each stored register image
    localparam logic [31:0] CTRL_MASK      = 32'h0000_01F3;
    localparam logic [31:0] BAUD_MASK      = 32'h0000_FFFF;
    localparam logic [31:0] INT_EN_MASK    = 32'h0000_003F;
    localparam logic [31:0] FIFO_CTRL_MASK = 32'h000F_0F00;
    localparam logic [31:0] RX_TMO_MASK    = 32'h0000_FFFF;

    function automatic logic [31:0] merge_wr(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [31:0] wm);
        return (cur & ~wm) | (wd & wm);
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// RX idle timeout: counts cycles with data waiting and no RX activity; hit pulses once per idle period.
// hit is combinational, asserted in the cycle the count reaches the threshold; threshold 0 disables.
module uart_rx_timeout
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_byte_strobe,
    input  logic        rx_pop,
    input  logic        rx_idle,
    input  logic [15:0] threshold,
    output logic        hit
);

    logic [15:0] cnt;
    logic        reload;
    logic        counting;

    assign reload   = rx_byte_strobe || rx_pop || rx_idle || (threshold == 16'd0);
    assign counting = !reload && (cnt < threshold);
    // Counter stops at the threshold, so the hit fires only once until a reload
    assign hit      = counting && ((cnt + 16'd1) == threshold);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= '0;
        end else if (counting) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_csr.sv
// UART control/status register file; RX timeout included only when UART_CSR_RX_TIMEOUT_EN is defined.
// Read data and error strobe one cycle after the request; no backpressure, TX pushes to a full FIFO are dropped.
module uart_csr
    import uart_pkg::*;
#(
    parameter  int DATA_WIDTH     = 32,
    parameter  int REG_ADDR_WIDTH = 4,
    parameter  int FIFO_DEPTH     = 16,
    localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
    input  logic [DATA_WIDTH-1:0]     reg_wdata,
    input  logic [DATA_WIDTH/8-1:0]   reg_wstrb,
    input  logic                      reg_wen,
    input  logic                      reg_ren,
    output logic [DATA_WIDTH-1:0]     reg_rdata,
    output logic                      reg_rvalid,
    output logic                      reg_error,
    output logic [7:0]                tx_wr_data,
    output logic                      tx_wr_en,
    input  logic                      tx_full,
    input  logic [LVL_W-1:0]          tx_level,
    input  logic [7:0]                rx_rd_data,
    output logic                      rx_rd_en,
    input  logic                      rx_empty,
    input  logic [LVL_W-1:0]          rx_level,
    input  logic                      rx_byte_strobe,
    input  logic                      frame_error,
    input  logic                      parity_error,
    input  logic                      overrun_error,
    output logic [15:0]               baud_divisor,
    output logic [LC_W-1:0]           line_ctrl,
    output logic                      baud_enable,
    output logic                      tx_fifo_reset,
    output logic                      rx_fifo_reset,
    output logic                      irq
);

    logic [DATA_WIDTH-1:0] wmask;
    logic [31:0]           wm32, wd32, rd32, addr32;
    logic [31:0]           ctrl_q, baud_q, int_en_q, fifo_ctrl_q, fifo_m, status_img;
    logic [INT_W-1:0]      int_stat_q, int_set, int_clr;
    logic                  frame_st, parity_st, overrun_st, tx_drop;
    logic                  addr_ok, rx_avail, tmo_hit;
    logic                  wr_ctrl, wr_tx, wr_baud, wr_int_en, wr_int_stat, wr_fifo;
    logic                  tx_push, tx_drop_set;
    logic [3:0]            rx_wm_eff;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            wmask[b*8 +: 8] = {8{reg_wstrb[b]}};
        end
    end

    assign wm32   = 32'(wmask);
    assign wd32   = 32'(reg_wdata);
    assign addr32 = 32'(reg_addr);

`ifdef UART_CSR_RX_TIMEOUT_EN
    logic [31:0] rx_tmo_q;
    logic        wr_rx_tmo;

    assign addr_ok   = addr32 <= ADDR_RX_TIMEOUT;
    assign wr_rx_tmo = reg_wen && (addr32 == ADDR_RX_TIMEOUT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_tmo_q <= '0;
        end else if (wr_rx_tmo) begin
            rx_tmo_q <= merge_wr(rx_tmo_q, wd32, wm32) & RX_TMO_MASK;
        end
    end

    uart_rx_timeout u_rx_timeout (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_byte_strobe (rx_byte_strobe),
        .rx_pop         (rx_rd_en),
        .rx_idle        (rx_level == '0),
        .threshold      (rx_tmo_q[15:0]),
        .hit            (tmo_hit)
    );
`else
    assign addr_ok = addr32 <= ADDR_FIFO_CTRL;
    assign tmo_hit = 1'b0;
`endif

    assign wr_ctrl     = reg_wen && (addr32 == ADDR_CTRL);
    assign wr_tx       = reg_wen && (addr32 == ADDR_TX_DATA) && wm32[0] && ctrl_q[0];
    assign wr_baud     = reg_wen && (addr32 == ADDR_BAUD_DIV);
    assign wr_int_en   = reg_wen && (addr32 == ADDR_INT_EN);
    assign wr_int_stat = reg_wen && (addr32 == ADDR_INT_STAT);
    assign wr_fifo     = reg_wen && (addr32 == ADDR_FIFO_CTRL);

    assign tx_push     = wr_tx && !tx_full;
    assign tx_drop_set = wr_tx && tx_full;
    assign rx_avail    = ctrl_q[1] && !rx_empty;
    assign fifo_m      = merge_wr(fifo_ctrl_q, wd32, wm32);
    assign rx_wm_eff   = (fifo_ctrl_q[19:16] == 4'd0) ? 4'd1 : fifo_ctrl_q[19:16];

    assign status_img = {8'(rx_level), 8'(tx_level), 7'd0, tx_drop, 3'd0,
                         overrun_st, parity_st, frame_st, rx_empty, tx_full};

    always_comb begin
        int_set              = '0;
        int_set[INT_TX_WM]   = 32'(tx_level) <= 32'(fifo_ctrl_q[11:8]);
        int_set[INT_RX_WM]   = 32'(rx_level) >= 32'(rx_wm_eff);
        int_set[INT_FRAME]   = frame_error;
        int_set[INT_PARITY]  = parity_error;
        int_set[INT_OVERRUN] = overrun_error;
        int_set[INT_RX_TMO]  = tmo_hit;
        int_clr = wr_int_stat ? (wd32[INT_W-1:0] & wm32[INT_W-1:0]) : '0;
    end

    always_comb begin
        rd32 = '0;
        case (addr32)
            ADDR_CTRL:       rd32 = ctrl_q;
            ADDR_STATUS:     rd32 = status_img;
            ADDR_RX_DATA:    rd32 = rx_avail ? {24'd0, rx_rd_data} : 32'h0000_0100;
            ADDR_BAUD_DIV:   rd32 = baud_q;
            ADDR_INT_EN:     rd32 = int_en_q;
            ADDR_INT_STAT:   rd32 = 32'(int_stat_q);
            ADDR_FIFO_CTRL:  rd32 = fifo_ctrl_q;
`ifdef UART_CSR_RX_TIMEOUT_EN
            ADDR_RX_TIMEOUT: rd32 = rx_tmo_q;
`endif
            default:         rd32 = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_rvalid    <= 1'b0;
            reg_rdata     <= '0;
            reg_error     <= 1'b0;
            rx_rd_en      <= 1'b0;
            tx_wr_en      <= 1'b0;
            tx_wr_data    <= '0;
            tx_fifo_reset <= 1'b0;
            rx_fifo_reset <= 1'b0;
            ctrl_q        <= CTRL_RST;
            baud_q        <= 32'(BAUD_RST);
            int_en_q      <= '0;
            fifo_ctrl_q   <= '0;
            int_stat_q    <= '0;
            frame_st      <= 1'b0;
            parity_st     <= 1'b0;
            overrun_st    <= 1'b0;
            tx_drop       <= 1'b0;
        end else begin
            reg_rvalid    <= reg_ren;
            reg_rdata     <= reg_ren ? DATA_WIDTH'(rd32) : '0;
            reg_error     <= (reg_ren || reg_wen) && !addr_ok;
            rx_rd_en      <= reg_ren && (addr32 == ADDR_RX_DATA) && rx_avail;
            tx_wr_en      <= tx_push;
            if (tx_push) begin
                tx_wr_data <= wd32[7:0];
            end
            tx_fifo_reset <= wr_fifo && fifo_m[0];
            rx_fifo_reset <= wr_fifo && fifo_m[1];
            if (wr_ctrl)   ctrl_q      <= merge_wr(ctrl_q, wd32, wm32) & CTRL_MASK;
            if (wr_baud)   baud_q      <= merge_wr(baud_q, wd32, wm32) & BAUD_MASK;
            if (wr_int_en) int_en_q    <= merge_wr(int_en_q, wd32, wm32) & INT_EN_MASK;
            if (wr_fifo)   fifo_ctrl_q <= fifo_m & FIFO_CTRL_MASK;
            // New events take priority over a same-cycle W1C
            int_stat_q <= (int_stat_q & ~int_clr) | int_set;
            frame_st   <= (frame_st   & ~int_clr[INT_FRAME])   | frame_error;
            parity_st  <= (parity_st  & ~int_clr[INT_PARITY])  | parity_error;
            overrun_st <= (overrun_st & ~int_clr[INT_OVERRUN]) | overrun_error;
            tx_drop    <= (tx_drop    & ~int_clr[INT_OVERRUN]) | tx_drop_set;
        end
    end

    assign baud_divisor = baud_q[15:0];
    assign line_ctrl    = ctrl_q[CTRL_LC_LSB +: LC_W];
    assign baud_enable  = ctrl_q[0] || ctrl_q[1];
    assign irq          = |(int_stat_q & int_en_q[INT_W-1:0]);

endmodule

// File: tb/tb_uart_csr.sv
// Directed-vector bench for uart_csr with hand-computed expected values.
module tb_uart_csr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_wen, reg_ren;
    logic [31:0] reg_rdata;
    logic        reg_rvalid, reg_error;
    logic [7:0]  tx_wr_data;
    logic        tx_wr_en, tx_full;
    logic [4:0]  tx_level;
    logic [7:0]  rx_rd_data;
    logic        rx_rd_en, rx_empty;
    logic [4:0]  rx_level;
    logic        rx_byte_strobe, frame_error, parity_error, overrun_error;
    logic [15:0] baud_divisor;
    logic [4:0]  line_ctrl;
    logic        baud_enable, tx_fifo_reset, rx_fifo_reset, irq;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] r_dat;
    logic        r_vld, r_err, r_pop;

    uart_csr dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_wstrb      (reg_wstrb),
        .reg_wen        (reg_wen),
        .reg_ren        (reg_ren),
        .reg_rdata      (reg_rdata),
        .reg_rvalid     (reg_rvalid),
        .reg_error      (reg_error),
        .tx_wr_data     (tx_wr_data),
        .tx_wr_en       (tx_wr_en),
        .tx_full        (tx_full),
        .tx_level       (tx_level),
        .rx_rd_data     (rx_rd_data),
        .rx_rd_en       (rx_rd_en),
        .rx_empty       (rx_empty),
        .rx_level       (rx_level),
        .rx_byte_strobe (rx_byte_strobe),
        .frame_error    (frame_error),
        .parity_error   (parity_error),
        .overrun_error  (overrun_error),
        .baud_divisor   (baud_divisor),
        .line_ctrl      (line_ctrl),
        .baud_enable    (baud_enable),
        .tx_fifo_reset  (tx_fifo_reset),
        .rx_fifo_reset  (rx_fifo_reset),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        reg_addr  = a;
        reg_wdata = d;
        reg_wstrb = s;
        reg_wen   = 1'b1;
        tick();
        reg_wen = 1'b0;
        r_err   = reg_error;
    endtask

    task automatic rd(input logic [3:0] a);
        reg_addr = a;
        reg_ren  = 1'b1;
        tick();
        reg_ren = 1'b0;
        r_dat   = reg_rdata;
        r_vld   = reg_rvalid;
        r_err   = reg_error;
        r_pop   = rx_rd_en;
    endtask

    initial begin
        rst_n = 1'b0;
        reg_addr = '0; reg_wdata = '0; reg_wstrb = '0; reg_wen = 1'b0; reg_ren = 1'b0;
        tx_full = 1'b0; tx_level = '0; rx_rd_data = '0; rx_empty = 1'b1; rx_level = '0;
        rx_byte_strobe = 1'b0; frame_error = 1'b0; parity_error = 1'b0; overrun_error = 1'b0;
        repeat (3) tick();

        chk("rst_baud_div", 32'(baud_divisor), 32'h4);
        chk("rst_line_ctrl", 32'(line_ctrl), 32'h3);
        chk("rst_outs", {26'd0, irq, baud_enable, reg_rvalid, tx_wr_en, rx_rd_en, reg_error}, 32'h0);
        rst_n = 1'b1;
        tick();

        chk("idle_rvalid", 32'(reg_rvalid), 32'h0);
        rd(4'd4);
        chk("rd_baud", r_dat, 32'h4);
        chk("rd_baud_vld", 32'(r_vld), 32'h1);
        tick();
        chk("rvalid_drop", {reg_rdata[30:0], reg_rvalid}, 32'h0);
        rd(4'd0);
        chk("rd_ctrl_rst", r_dat, 32'h30);
        rd(4'd6);
        chk("int_stat_txwm0", r_dat, 32'h1);

        // CTRL full write, then byte-1-only write clearing line_ctrl[4]
        wr(4'd0, 32'h1F3, 4'hF);
        chk("line_ctrl_1f", 32'(line_ctrl), 32'h1F);
        chk("baud_en", 32'(baud_enable), 32'h1);
        wr(4'd0, 32'h0, 4'b0010);
        rd(4'd0);
        chk("ctrl_strb", r_dat, 32'hF3);

        wr(4'd4, 32'hABCD, 4'b0001);
        chk("baud_b0", 32'(baud_divisor), 32'hCD);
        wr(4'd4, 32'h1200, 4'b0010);
        chk("baud_b1", 32'(baud_divisor), 32'h12CD);

        wr(4'd2, 32'h3C, 4'hF);
        chk("tx_push", {23'd0, tx_wr_en, tx_wr_data}, 32'h13C);
        tick();
        chk("tx_push_end", 32'(tx_wr_en), 32'h0);

        tx_full = 1'b1;
        wr(4'd2, 32'h55, 4'hF);
        chk("tx_full_nopush", 32'(tx_wr_en), 32'h0);
        rd(4'd1);
        chk("status_drop", r_dat, 32'h103);
        wr(4'd6, 32'h10, 4'hF);
        tx_full = 1'b0;
        rd(4'd1);
        chk("status_drop_clr", r_dat, 32'h2);

        rx_empty = 1'b0; rx_rd_data = 8'hA5; rx_level = 5'd2;
        rd(4'd3);
        chk("rx_data", r_dat, 32'hA5);
        chk("rx_pop", 32'(r_pop), 32'h1);
        tick();
        chk("rx_pop_end", 32'(rx_rd_en), 32'h0);
        rx_empty = 1'b1;
        rd(4'd3);
        chk("rx_empty_rd", r_dat, 32'h100);
        chk("rx_empty_nopop", 32'(r_pop), 32'h0);

        // RX watermark interrupt and set-beats-clear on frame error
        wr(4'd7, 32'h0004_0000, 4'hF);
        rx_level = 5'd3;
        wr(4'd5, 32'h2, 4'hF);
        wr(4'd6, 32'h3F, 4'hF);
        chk("irq_below_wm", 32'(irq), 32'h0);
        rx_level = 5'd4;
        tick();
        chk("irq_at_wm", 32'(irq), 32'h1);
        rd(4'd6);
        chk("int_stat_wm", r_dat, 32'h3);
        rx_level = 5'd0;
        frame_error = 1'b1;
        wr(4'd6, 32'h06, 4'hF);
        frame_error = 1'b0;
        rd(4'd6);
        chk("int_set_wins", r_dat, 32'h5);
        chk("irq_cleared", 32'(irq), 32'h0);
        rd(4'd1);
        chk("status_frame", r_dat, 32'h6);

        wr(4'd7, 32'h0004_0003, 4'hF);
        chk("fifo_rst_pulse", {30'd0, rx_fifo_reset, tx_fifo_reset}, 32'h3);
        tick();
        chk("fifo_rst_end", {30'd0, rx_fifo_reset, tx_fifo_reset}, 32'h0);
        rd(4'd7);
        chk("fifo_ctrl_rd", r_dat, 32'h0004_0000);

        rd(4'd12);
        chk("bad_rd", {r_dat[29:0], r_vld, r_err}, 32'h3);
        wr(4'd12, 32'hFFFF_FFFF, 4'hF);
        chk("bad_wr_err", 32'(r_err), 32'h1);
        rd(4'd0);
        chk("bad_wr_ctrl", r_dat, 32'hF3);
        rd(4'd4);
        chk("bad_wr_baud", r_dat, 32'h12CD);

        // Simultaneous write and read of BAUD_DIV returns the old value
        reg_addr = 4'd4; reg_wdata = 32'h7; reg_wstrb = 4'hF; reg_wen = 1'b1; reg_ren = 1'b1;
        tick();
        reg_wen = 1'b0; reg_ren = 1'b0;
        chk("rw_old", reg_rdata, 32'h12CD);
        chk("rw_new", 32'(baud_divisor), 32'h7);

`ifdef UART_CSR_RX_TIMEOUT_EN
        wr(4'd8, 32'd10, 4'hF);
        rd(4'd8);
        chk("tmo_reg", {r_dat[30:0], r_err}, 32'h14);
        wr(4'd6, 32'h3F, 4'hF);
        rx_level = 5'd1;
        repeat (20) tick();
        rd(4'd6);
        chk("tmo_set", r_dat, 32'h21);
        wr(4'd6, 32'h20, 4'hF);
        repeat (20) tick();
        rd(4'd6);
        chk("tmo_once", r_dat, 32'h1);
        rx_level = 5'd0;
`else
        rd(4'd8);
        chk("addr8_err", {r_dat[30:0], r_err}, 32'h1);
`endif

        // Reset asserted together with an RX_DATA read
        wr(4'd0, 32'h3, 4'h1);
        rx_empty = 1'b0;
        reg_addr = 4'd3; reg_ren = 1'b1; rst_n = 1'b0;
        tick();
        reg_ren = 1'b0;
        chk("rst_mid_rd", {29'd0, reg_rvalid, rx_rd_en, reg_error}, 32'h0);
        chk("rst_mid_baud", 32'(baud_divisor), 32'h4);
        rst_n = 1'b1;
        rx_empty = 1'b1;
        tick();
        rd(4'd0);
        chk("ctrl_after_rst", r_dat, 32'h30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
